// File: rtl/metastab_tuner.sv
// rtl/metastab_tuner.sv - per-channel delay-line tuner that centres a metastable TRNG flop
//
// Purpose:
//   Each channel watches the sampled output of a comparator flop whose clock
//   and data paths pass through programmable delay lines. A window of SR_W
//   samples is collected. Too few ones means the data edge arrives late, so
//   the data delay is shortened first and the clock delay lengthened once data
//   is at zero. Too many ones is the mirror case. A balanced window counts
//   toward lock. When both codes are pinned against their limits the channel
//   flags saturation and stops steering until restarted.
//
// Ports:
//   clk                    in  1               single rising-edge clock
//   rst                    in  1               synchronous active-high reset
//   enable                 in  1               global run; low parks every channel in IDLE
//   restart                in  NUM_CH          per-channel synchronous clear
//   data_in                in  NUM_CH          sampled comparator-flop outputs
//   clk_coarse_delay_ctrl  out NUM_CH*CODE_W   clock-path delay code, ch i at [i*CODE_W +: CODE_W]
//   data_coarse_delay_ctrl out NUM_CH*CODE_W   data-path delay code, same packing
//   delay_update           out NUM_CH          one-cycle pulse when a code changed
//   locked                 out NUM_CH          LOCK_N consecutive balanced windows seen
//   saturated              out NUM_CH          sticky: no further step possible
//   all_locked             out 1               every channel locked

module metastab_tuner #(
  parameter int NUM_CH     = 4,
  parameter int DL_LENGTH  = 64,
  parameter int CODE_W     = 6,
  parameter int SR_W       = 8,
  parameter int LO_TH      = SR_W / 4,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_N     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        restart,
  input  logic [NUM_CH-1:0]        data_in,
  output logic [NUM_CH*CODE_W-1:0] clk_coarse_delay_ctrl,
  output logic [NUM_CH*CODE_W-1:0] data_coarse_delay_ctrl,
  output logic [NUM_CH-1:0]        delay_update,
  output logic [NUM_CH-1:0]        locked,
  output logic [NUM_CH-1:0]        saturated,
  output logic                     all_locked
);

  localparam int PC_W = $clog2(SR_W + 1);
  localparam int FC_W = $clog2(SR_W + 1);
  localparam int ST_W = $clog2(SETTLE_CYC + 1);
  localparam int LC_W = $clog2(LOCK_N + 1);

  localparam logic [PC_W-1:0]   LO_V     = PC_W'(LO_TH);
  localparam logic [PC_W-1:0]   HI_V     = PC_W'(SR_W - LO_TH);
  localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(DL_LENGTH - 1);
  localparam logic [FC_W-1:0]   FILL_END = FC_W'(SR_W - 1);
  localparam logic [ST_W-1:0]   SETL_END = ST_W'(SETTLE_CYC - 1);
  localparam logic [LC_W-1:0]   LOCK_V   = LC_W'(LOCK_N);
  localparam logic [LC_W-1:0]   LOCK_M1  = LC_W'(LOCK_N - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_EVAL   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  function automatic logic [PC_W-1:0] popcount(input logic [SR_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int k = 0; k < SR_W; k++) begin
      n = n + PC_W'(v[k]);
    end
    return n;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]        state;
    logic [SR_W-1:0]   sr;
    logic [FC_W-1:0]   fill_cnt;
    logic [ST_W-1:0]   settle_cnt;
    logic [CODE_W-1:0] clk_code;
    logic [CODE_W-1:0] data_code;
    logic [LC_W-1:0]   lock_cnt;
    logic              lock_q;
    logic              sat_q;
    logic              upd_q;
    logic [PC_W-1:0]   ones;
    logic              too_low;
    logic              too_high;

    assign ones     = popcount(sr);
    assign too_low  = (ones < LO_V);
    assign too_high = (ones > HI_V);

    always_ff @(posedge clk) begin
      if (rst || restart[i]) begin
        state      <= S_IDLE;
        sr         <= '0;
        fill_cnt   <= '0;
        settle_cnt <= '0;
        clk_code   <= '0;
        data_code  <= '0;
        lock_cnt   <= '0;
        lock_q     <= 1'b0;
        sat_q      <= 1'b0;
        upd_q      <= 1'b0;
      end else if (!enable) begin
        // Parking drops any evaluation in flight; codes and saturation survive.
        state      <= S_IDLE;
        sr         <= '0;
        fill_cnt   <= '0;
        settle_cnt <= '0;
        lock_cnt   <= '0;
        lock_q     <= 1'b0;
        upd_q      <= 1'b0;
      end else begin
        upd_q <= 1'b0;
        case (state)
          S_IDLE: begin
            state    <= S_FILL;
            sr       <= '0;
            fill_cnt <= '0;
          end
          S_FILL: begin
            sr       <= (sr << 1) | SR_W'(data_in[i]);
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == FILL_END) begin
              state <= S_EVAL;
            end
          end
          S_EVAL: begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            if (sat_q) begin
              lock_cnt <= '0;
              lock_q   <= 1'b0;
            end else if (too_low) begin
              // Data edge is late: pull data earlier before pushing clock later.
              lock_cnt <= '0;
              lock_q   <= 1'b0;
              if (data_code != '0) begin
                data_code <= data_code - 1'b1;
                upd_q     <= 1'b1;
              end else if (clk_code != MAX_CODE) begin
                clk_code <= clk_code + 1'b1;
                upd_q    <= 1'b1;
              end else begin
                sat_q <= 1'b1;
              end
            end else if (too_high) begin
              lock_cnt <= '0;
              lock_q   <= 1'b0;
              if (clk_code != '0) begin
                clk_code <= clk_code - 1'b1;
                upd_q    <= 1'b1;
              end else if (data_code != MAX_CODE) begin
                data_code <= data_code + 1'b1;
                upd_q     <= 1'b1;
              end else begin
                sat_q <= 1'b1;
              end
            end else begin
              if (lock_cnt != LOCK_V) begin
                lock_cnt <= lock_cnt + 1'b1;
              end
              if (lock_cnt >= LOCK_M1) begin
                lock_q <= 1'b1;
              end
            end
          end
          S_SETTLE: begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETL_END) begin
              state    <= S_FILL;
              sr       <= '0;
              fill_cnt <= '0;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end

    assign clk_coarse_delay_ctrl[i*CODE_W +: CODE_W]  = clk_code;
    assign data_coarse_delay_ctrl[i*CODE_W +: CODE_W] = data_code;
    assign delay_update[i] = upd_q;
    assign locked[i]       = lock_q;
    assign saturated[i]    = sat_q;
  end

  assign all_locked = &locked;

endmodule

// File: tb/tb_metastab_tuner.sv
// tb/tb_metastab_tuner.sv - self-checking bench for metastab_tuner
module tb_metastab_tuner;

  localparam int NUM_CH    = 4;
  localparam int CODE_W    = 6;
  localparam int SR_W      = 8;
  localparam int LO_TH     = SR_W / 4;
  localparam int HI_TH     = SR_W - LO_TH;
  localparam int SETTLE    = 4;
  localparam int LOCK_N    = 4;
  localparam int MAXC      = 63;
  localparam int PERIOD    = SR_W + 1 + SETTLE;
  localparam int TOT       = 2 * NUM_CH * CODE_W + 3 * NUM_CH + 1;

  logic                     clk;
  logic                     rst;
  logic                     enable;
  logic [NUM_CH-1:0]        restart;
  logic [NUM_CH-1:0]        data_in;
  logic [NUM_CH*CODE_W-1:0] clk_coarse_delay_ctrl;
  logic [NUM_CH*CODE_W-1:0] data_coarse_delay_ctrl;
  logic [NUM_CH-1:0]        delay_update;
  logic [NUM_CH-1:0]        locked;
  logic [NUM_CH-1:0]        saturated;
  logic                     all_locked;

  int n_tests = 0;
  int n_fail  = 0;

  metastab_tuner dut (
    .clk                    (clk),
    .rst                    (rst),
    .enable                 (enable),
    .restart                (restart),
    .data_in                (data_in),
    .clk_coarse_delay_ctrl  (clk_coarse_delay_ctrl),
    .data_coarse_delay_ctrl (data_coarse_delay_ctrl),
    .delay_update           (delay_update),
    .locked                 (locked),
    .saturated              (saturated),
    .all_locked             (all_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the run since enable was seen, and a
  // running count of ones in the current window.
  int m_clk[NUM_CH];
  int m_data[NUM_CH];
  int m_sat[NUM_CH];
  int m_lcnt[NUM_CH];
  int m_lock[NUM_CH];
  int m_upd[NUM_CH];
  int m_pos[NUM_CH];
  int m_ones[NUM_CH];

  task automatic model_step();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_upd[ch] = 0;
      if (rst || restart[ch]) begin
        m_clk[ch] = 0; m_data[ch] = 0; m_sat[ch] = 0; m_lcnt[ch] = 0;
        m_lock[ch] = 0; m_pos[ch] = -1; m_ones[ch] = 0;
      end else if (!enable) begin
        m_pos[ch] = -1; m_ones[ch] = 0; m_lcnt[ch] = 0; m_lock[ch] = 0;
      end else begin
        m_pos[ch]++;
        if (m_pos[ch] >= 1) begin
          int ph;
          ph = (m_pos[ch] - 1) % PERIOD;
          if (ph < SR_W) begin
            m_ones[ch] += int'(data_in[ch]);
          end else if (ph == SR_W) begin
            if (m_sat[ch] != 0) begin
              m_lcnt[ch] = 0; m_lock[ch] = 0;
            end else if (m_ones[ch] < LO_TH) begin
              m_lcnt[ch] = 0; m_lock[ch] = 0;
              if (m_data[ch] > 0) begin m_data[ch]--; m_upd[ch] = 1; end
              else if (m_clk[ch] < MAXC) begin m_clk[ch]++; m_upd[ch] = 1; end
              else m_sat[ch] = 1;
            end else if (m_ones[ch] > HI_TH) begin
              m_lcnt[ch] = 0; m_lock[ch] = 0;
              if (m_clk[ch] > 0) begin m_clk[ch]--; m_upd[ch] = 1; end
              else if (m_data[ch] < MAXC) begin m_data[ch]++; m_upd[ch] = 1; end
              else m_sat[ch] = 1;
            end else begin
              m_lcnt[ch] = (m_lcnt[ch] + 1 > LOCK_N) ? LOCK_N : m_lcnt[ch] + 1;
              m_lock[ch] = (m_lcnt[ch] == LOCK_N) ? 1 : 0;
            end
            m_ones[ch] = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [TOT-1:0] exp_vec();
    logic [NUM_CH*CODE_W-1:0] ec, ed;
    logic [NUM_CH-1:0] eu, el, es;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ec[ch*CODE_W +: CODE_W] = CODE_W'(m_clk[ch]);
      ed[ch*CODE_W +: CODE_W] = CODE_W'(m_data[ch]);
      eu[ch] = (m_upd[ch] != 0);
      el[ch] = (m_lock[ch] != 0);
      es[ch] = (m_sat[ch] != 0);
    end
    return {ec, ed, eu, el, es, &el};
  endfunction

  logic [TOT-1:0] act;
  assign act = {clk_coarse_delay_ctrl, data_coarse_delay_ctrl, delay_update,
                locked, saturated, all_locked};

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; restart = '0; data_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; restart = '1; data_in = '1;
    tick();
    n_tests++;
    if (act !== '0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=0", act);
    end
    rst = 1'b0; enable = 1'b0; restart = '0;
    for (int c = 0; c < 100; c++) begin
      data_in = NUM_CH'($urandom);
      tick();
      n_tests++;
      if (act !== exp_vec() || act !== '0) begin
        n_fail++; $display("FAIL idle_hold c=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
  endtask

  task automatic test_drift_saturate();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 842; c++) begin
      data_in = {{(NUM_CH-1){c[0]}}, 1'b0};
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL drift c=%0d got=%h exp=%h", c, act, exp_vec());
      end
      if (c == 9 || c == 22) begin
        n_tests++;
        if (delay_update !== 4'b0001 || clk_coarse_delay_ctrl !== 24'(c == 9 ? 1 : 2)) begin
          n_fail++;
          $display("FAIL drift_first_steps c=%0d upd=%b clk=%h exp_clk=%0d", c, delay_update,
                   clk_coarse_delay_ctrl, (c == 9 ? 1 : 2));
        end
      end
    end
    n_tests++;
    if (saturated !== 4'b0001 || clk_coarse_delay_ctrl[CODE_W-1:0] !== 6'd63) begin
      n_fail++;
      $display("FAIL saturate sat=%b clk0=%0d exp sat=0001 clk0=63", saturated,
               clk_coarse_delay_ctrl[CODE_W-1:0]);
    end
    restart = 4'b0001;
    tick();
    restart = '0;
    n_tests++;
    if (act !== exp_vec() || saturated[0] !== 1'b0 || clk_coarse_delay_ctrl[CODE_W-1:0] !== '0) begin
      n_fail++; $display("FAIL restart_clear got=%h exp=%h", act, exp_vec());
    end
  endtask

  task automatic test_data_stepdown();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 92; c++) begin
      data_in = {{(NUM_CH-1){c[0]}}, (c < 3 * PERIOD) ? 1'b1 : 1'b0};
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL stepdown c=%0d got=%h exp=%h", c, act, exp_vec());
      end
      if (c == 3 * PERIOD || c == 7 * PERIOD) begin
        n_tests++;
        if (data_coarse_delay_ctrl[CODE_W-1:0] !== ((c == 3 * PERIOD) ? 6'd3 : 6'd0) ||
            clk_coarse_delay_ctrl[CODE_W-1:0] !== ((c == 3 * PERIOD) ? 6'd0 : 6'd1)) begin
          n_fail++;
          $display("FAIL stepdown_codes c=%0d data0=%0d clk0=%0d", c,
                   data_coarse_delay_ctrl[CODE_W-1:0], clk_coarse_delay_ctrl[CODE_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 75; c++) begin
      logic b2;
      b2 = (c >= 49 && c <= 61) ? (c != 53) : c[0];
      data_in = {c[0], b2, c[0], c[0]};
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL lock c=%0d got=%h exp=%h", c, act, exp_vec());
      end
      if (c == 47 || c == 48) begin
        n_tests++;
        if (all_locked !== (c == 48) || locked !== ((c == 48) ? 4'hf : 4'h0)) begin
          n_fail++; $display("FAIL lock_time c=%0d locked=%b all=%b", c, locked, all_locked);
        end
      end
      if (c == 61) begin
        n_tests++;
        if (locked !== 4'b1011 || all_locked !== 1'b0 || delay_update !== 4'b0100) begin
          n_fail++;
          $display("FAIL unlock_ch2 locked=%b all=%b upd=%b exp 1011/0/0100", locked, all_locked,
                   delay_update);
        end
      end
    end
  endtask

  task automatic test_enable_abort();
    do_reset();
    for (int c = 0; c < 80; c++) begin
      enable  = (c == 55 || c == 65) ? 1'b0 : 1'b1;
      data_in = (c < 55) ? {NUM_CH{c[0]}} : '0;
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL enable_abort c=%0d got=%h exp=%h", c, act, exp_vec());
      end
      if (c == 55 || c == 65) begin
        n_tests++;
        if (locked !== '0 || delay_update !== '0 || clk_coarse_delay_ctrl !== '0) begin
          n_fail++;
          $display("FAIL abort_hold c=%0d locked=%b upd=%b clk=%h exp 0", c, locked,
                   delay_update, clk_coarse_delay_ctrl);
        end
      end
      if (c == 75) begin
        n_tests++;
        if (clk_coarse_delay_ctrl !== {NUM_CH{6'd1}} || delay_update !== '1) begin
          n_fail++;
          $display("FAIL refill_eval clk=%h upd=%b exp clk=%h upd=1111", clk_coarse_delay_ctrl,
                   delay_update, {NUM_CH{6'd1}});
        end
      end
    end
  endtask

  task automatic test_random();
    int bias[NUM_CH];
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        for (int ch = 0; ch < NUM_CH; ch++) bias[ch] = $urandom_range(0, 100);
      end
      rst    = ($urandom_range(0, 999) == 0);
      enable = ($urandom_range(0, 99) >= 3);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        restart[ch] = ($urandom_range(0, 599) == 0);
        data_in[ch] = ($urandom_range(0, 99) < bias[ch]);
      end
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL random c=%0d got=%h exp=%h", c, act, exp_vec());
      end
    end
    rst = 1'b0; enable = 1'b0; restart = '0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; restart = '0; data_in = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_clk[ch] = 0; m_data[ch] = 0; m_sat[ch] = 0; m_lcnt[ch] = 0;
      m_lock[ch] = 0; m_upd[ch] = 0; m_pos[ch] = -1; m_ones[ch] = 0;
    end
    @(negedge clk);
    test_reset();
    test_drift_saturate();
    test_data_stepdown();
    test_lock();
    test_enable_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/metastab_tuner.md
METASTAB_TUNER -- requirements
Module: metastab_tuner

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent TRNG tuning channels.
REQ-002 SHALL have parameter DL_LENGTH, default 64, delay-line taps; max code = DL_LENGTH-1.
REQ-003 SHALL have parameter CODE_W, default 6, code width, >= clog2(DL_LENGTH).
REQ-004 SHALL have parameter SR_W, default 8, samples per evaluation window.
REQ-005 SHALL have parameter LO_TH, default SR_W/4; HI_TH = SR_W-LO_TH; balanced band LO_TH..HI_TH inclusive.
REQ-006 SHALL have parameter SETTLE_CYC, default 4, idle cycles after each evaluation (>=1).
REQ-007 SHALL have parameter LOCK_N, default 4, consecutive balanced evaluations required for lock.
REQ-008 SHALL have ports: clk in 1 (single clock, all logic on rising edge); rst in 1 (synchronous, active-high).
REQ-009 SHALL have ports: enable in 1 global run; restart in NUM_CH per-channel synchronous clear; data_in in NUM_CH sampled comparator-flop outputs.
REQ-010 SHALL have ports: clk_coarse_delay_ctrl out NUM_CH*CODE_W, data_coarse_delay_ctrl out NUM_CH*CODE_W, channel i at bits [i*CODE_W +: CODE_W].
REQ-011 SHALL have ports: delay_update out NUM_CH pulse, locked out NUM_CH, saturated out NUM_CH, all_locked out 1.

Function
REQ-012 Each channel SHALL run its own FSM: IDLE, FILL, EVAL, SETTLE; channels fully independent.
REQ-013 IDLE -> FILL when enable=1; FILL shifts data_in[i] into SR_W-bit register for exactly SR_W cycles, then EVAL.
REQ-014 EVAL lasts one cycle: ones = popcount(shift register); SETTLE follows for SETTLE_CYC cycles (no sampling), then FILL with cleared shift register.
REQ-015 Evaluation period SHALL be SR_W+1+SETTLE_CYC cycles (13 at defaults).
REQ-016 ones < LO_TH: if data code > 0 decrement data code, else if clk code < DL_LENGTH-1 increment clk code, else set saturated.
REQ-017 ones > HI_TH: if clk code > 0 decrement clk code, else if data code < DL_LENGTH-1 increment data code, else set saturated.
REQ-018 Otherwise balanced: codes unchanged, lock counter increments (saturating at LOCK_N).
REQ-019 At most one of the two codes SHALL change per evaluation, by exactly 1; codes never wrap.
REQ-020 New code and delay_update[i]=1 SHALL be visible the cycle after EVAL; delay_update is a 1-cycle pulse, only when a code changed.
REQ-021 locked[i] SHALL assert the cycle after the LOCK_N-th consecutive balanced EVAL; any step clears lock counter and locked[i] with the same timing as delay_update.
REQ-022 saturated[i] SHALL be sticky until rst or restart[i]; while set, codes hold and lock counter is cleared.
REQ-023 all_locked SHALL be AND of locked[NUM_CH-1:0], registered combinationally from locked (no extra latency).
REQ-024 enable=0 in any state: next state IDLE, shift register and fill counter cleared, codes held, locked cleared, saturated held.
REQ-025 restart[i]=1: channel i codes, shift register, counters, locked, saturated cleared to 0 next cycle, state IDLE; restart wins over a simultaneous EVAL.
REQ-026 Enable drop during EVAL SHALL abort the evaluation: no code change, no delay_update.

Reset
REQ-027 rst=1 SHALL set all FSMs to IDLE and all outputs, codes, counters and shift registers to 0 at the next rising edge; rst overrides enable and restart.

Verification
REQ-028 rst pulse, enable=0 -> all outputs 0, FSMs IDLE, nothing changes over 100 cycles.
REQ-029 Defaults, enable at cycle 0, data_in[0]=0 constant -> clk code ch0 = 1 with delay_update at cycle 10, then +1 every 13 cycles; other channels with balanced input unchanged.
REQ-030 data_in[0]=1 for 3 evaluations (data code 3), then 0 -> data code 2,1,0 then clk code 1 on successive evaluations.
REQ-031 data_in[0]=0 indefinitely -> clk code reaches 63; next evaluation sets saturated[0], codes hold, no delay_update; restart[0] clears all to 0.
REQ-032 data_in alternating 0/1 on all channels -> no delay_update, locked on all channels and all_locked after 4th evaluation (cycle 49); one ones=7 window on ch2 drops locked[2] and all_locked with the step.
REQ-033 enable deasserted mid-FILL and at EVAL cycle -> no code change, locked cleared, FILL restarts from empty on re-enable.
